// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Top-level game-flow controller for the flappy game. It sequences the game
//   through IDLE -> READY countdown -> PLAY, which can go to PAUSE. On a
//   collision it enters a DYING freeze window, then either starts another life
//   or ends in OVER. It also gates bird flaps, freezes physics and scrolling
//   outside active play, and keeps a saturating score plus a high score.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   frame_tick  one-cycle pulse per video frame
//   flap_btn    flap button level (only rising edges act)
//   pause_btn   pause button level (only rising edges act)
//   collision   collision level from the detector
//   score_inc   one-cycle pulse when the bird passes a pipe
//   state       encoded state: IDLE=0 READY=1 PLAY=2 PAUSE=3 DYING=4 OVER=5
//   game_rst    reset for pipe/bird logic: high in IDLE, and for one cycle
//               when DYING hands over to READY
//   freeze      holds physics and scrolling in every state except PLAY
//   flap_pulse  one-cycle flap command to bird physics
//   score       current score, saturating
//   high_score  best score since rst
//   lives_left  remaining lives
//   new_record  set in OVER when the finished game beat high_score
module game_flow_ctrl #(
  parameter int LIVES        = 3,
  parameter int READY_FRAMES = 60,
  parameter int DEATH_FRAMES = 30,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               flap_btn,
  input  logic               pause_btn,
  input  logic               collision,
  input  logic               score_inc,
  output logic [2:0]         state,
  output logic               game_rst,
  output logic               freeze,
  output logic               flap_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [3:0]         lives_left,
  output logic               new_record
);

  localparam int CNT_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DYING = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   countdown, countdown_d;
  logic [SCORE_W-1:0] score_d, high_score_d;
  logic [3:0]         lives_d;
  logic               new_record_d;
  logic               flap_prev, pause_prev;
  logic               flap_edge, pause_edge;
  logic               cnt_expire;
  logic               dying_to_ready;

  // Score stops at all-ones instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  assign flap_edge  = flap_btn & ~flap_prev;
  assign pause_edge = pause_btn & ~pause_prev;

  // The last frame of a READY or DYING window.
  assign cnt_expire = frame_tick & (countdown == CNT_W'(1));

  // game_rst has to pulse in the same cycle that DYING hands over to READY,
  // so it is decoded from the current inputs rather than from a register.
  assign dying_to_ready = (state_q == DYING) & cnt_expire & (lives_left != 4'd0);

  assign state    = state_q;
  assign freeze   = (state_q != PLAY);
  assign game_rst = (state_q == IDLE) | dying_to_ready;

  always_comb begin
    state_d      = state_q;
    countdown_d  = countdown;
    score_d      = score;
    high_score_d = high_score;
    lives_d      = lives_left;
    new_record_d = new_record;
    case (state_q)
      IDLE: begin
        if (flap_edge) begin
          state_d      = READY;
          countdown_d  = CNT_W'(READY_FRAMES);
          score_d      = '0;
          lives_d      = 4'(LIVES);
          new_record_d = 1'b0;
        end
      end
      READY: begin
        if (frame_tick) begin
          countdown_d = countdown - CNT_W'(1);
          if (cnt_expire) state_d = PLAY;
        end
      end
      PLAY: begin
        // A pass and a hit in the same cycle still count the pass.
        if (score_inc) score_d = sat_inc(score);
        if (collision) begin
          state_d     = DYING;
          lives_d     = lives_left - 4'd1;
          countdown_d = CNT_W'(DEATH_FRAMES);
        end else if (pause_edge) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_edge) state_d = PLAY;
      end
      DYING: begin
        if (frame_tick) begin
          countdown_d = countdown - CNT_W'(1);
          if (cnt_expire) begin
            if (lives_left == 4'd0) begin
              state_d = OVER;
              if (score > high_score) begin
                high_score_d = score;
                new_record_d = 1'b1;
              end
            end else begin
              state_d     = READY;
              countdown_d = CNT_W'(READY_FRAMES);
            end
          end
        end
      end
      OVER: begin
        if (flap_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      countdown  <= '0;
      score      <= '0;
      high_score <= '0;
      lives_left <= 4'(LIVES);
      new_record <= 1'b0;
      flap_pulse <= 1'b0;
      flap_prev  <= 1'b0;
      pause_prev <= 1'b0;
    end else begin
      state_q    <= state_d;
      countdown  <= countdown_d;
      score      <= score_d;
      high_score <= high_score_d;
      lives_left <= lives_d;
      new_record <= new_record_d;
      flap_pulse <= (state_q == PLAY) & flap_edge;
      flap_prev  <= flap_btn;
      pause_prev <= pause_btn;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       frame_tick, flap_btn, pause_btn, collision, score_inc;
  logic [2:0] state;
  logic       game_rst, freeze, flap_pulse, new_record;
  logic [9:0] score, high_score;
  logic [3:0] lives_left;

  // Instance B: narrow score, short windows
  logic       b_tick, b_flap, b_pause, b_coll, b_inc;
  logic [2:0] b_state;
  logic       b_game_rst, b_freeze, b_flap_pulse, b_new_record;
  logic [2:0] b_score, b_high_score;
  logic [3:0] b_lives_left;

  int n_cmp = 0;
  int n_err = 0;

  game_flow_ctrl dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap_btn(flap_btn),
    .pause_btn(pause_btn), .collision(collision), .score_inc(score_inc),
    .state(state), .game_rst(game_rst), .freeze(freeze), .flap_pulse(flap_pulse),
    .score(score), .high_score(high_score), .lives_left(lives_left),
    .new_record(new_record)
  );

  game_flow_ctrl #(.LIVES(3), .READY_FRAMES(2), .DEATH_FRAMES(2), .SCORE_W(3)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(b_tick), .flap_btn(b_flap),
    .pause_btn(b_pause), .collision(b_coll), .score_inc(b_inc),
    .state(b_state), .game_rst(b_game_rst), .freeze(b_freeze), .flap_pulse(b_flap_pulse),
    .score(b_score), .high_score(b_high_score), .lives_left(b_lives_left),
    .new_record(b_new_record)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1; tick();
      score_inc = 1'b0; tick();
    end
  endtask

  task automatic lose_life();
    collision = 1'b1; tick();
    collision = 1'b0;
    frames(30);
  endtask

  task automatic flap_press();
    flap_btn = 1'b1; tick();
    flap_btn = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1;
    {frame_tick, flap_btn, pause_btn, collision, score_inc} = '0;
    {b_tick, b_flap, b_pause, b_coll, b_inc} = '0;
    tick(); tick();

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_high", high_score, 0);
    chk("rst_lives", lives_left, 3);
    chk("rst_nrec", new_record, 0);
    chk("rst_flap_pulse", flap_pulse, 0);
    chk("rst_game_rst", game_rst, 1);
    chk("rst_freeze", freeze, 1);
    rst = 1'b0;
    tick();

    // 1: start, READY countdown of exactly 60 ticks
    flap_btn = 1'b1; tick();
    chk("t1_ready", state, 1);
    chk("t1_score", score, 0);
    chk("t1_lives", lives_left, 3);
    chk("t1_game_rst", game_rst, 0);
    chk("t1_freeze_ready", freeze, 1);
    flap_btn = 1'b0;
    frames(10);
    flap_press();   // ignored in READY
    pause_btn = 1'b1; tick(); pause_btn = 1'b0; tick();   // ignored in READY
    chk("t1_ignore_btn", state, 1);
    frames(49);
    chk("t1_still_ready", state, 1);
    frames(1);
    chk("t1_play", state, 2);
    chk("t1_freeze_play", freeze, 0);

    // 2: score and flap pulse
    incs(5);
    chk("t2_score", score, 5);
    flap_btn = 1'b1;
    chk("t2_pulse_before", flap_pulse, 0);
    tick();
    chk("t2_pulse_on", flap_pulse, 1);
    tick();
    chk("t2_pulse_off", flap_pulse, 0);
    tick();
    chk("t2_pulse_held", flap_pulse, 0);
    flap_btn = 1'b0; tick();

    // 3: collision beats pause, DYING -> READY with game_rst pulse
    collision = 1'b1; pause_btn = 1'b1; tick();
    chk("t3_dying", state, 4);
    chk("t3_lives", lives_left, 2);
    chk("t3_freeze", freeze, 1);
    collision = 1'b0; pause_btn = 1'b0;
    frames(29);
    chk("t3_still_dying", state, 4);
    chk("t3_no_game_rst", game_rst, 0);
    frame_tick = 1'b1; #1;
    chk("t3_game_rst_pulse", game_rst, 1);
    tick(); frame_tick = 1'b0; #1;
    chk("t3_ready", state, 1);
    chk("t3_game_rst_off", game_rst, 0);
    chk("t3_score_kept", score, 5);
    frames(60);
    chk("t3_play", state, 2);

    // 4: pause / resume
    pause_btn = 1'b1; tick();
    chk("t4_pause", state, 3);
    chk("t4_freeze", freeze, 1);
    pause_btn = 1'b0;
    collision = 1'b1; score_inc = 1'b1; flap_btn = 1'b1; tick();
    collision = 1'b0; score_inc = 1'b0; flap_btn = 1'b0;
    chk("t4_no_pulse", flap_pulse, 0);
    frames(3);
    chk("t4_held", state, 3);
    chk("t4_score_held", score, 5);
    chk("t4_lives_held", lives_left, 2);
    pause_btn = 1'b1; tick();
    chk("t4_resume", state, 2);
    chk("t4_score_resume", score, 5);
    pause_btn = 1'b0; tick();

    // 5: lose all lives with score 7, then a game with score 4
    incs(1);
    lose_life();
    chk("t5_ready2", state, 1);
    chk("t5_lives1", lives_left, 1);
    frames(60);
    collision = 1'b1; score_inc = 1'b1; tick();
    collision = 1'b0; score_inc = 1'b0;
    chk("t5_inc_with_hit", score, 7);
    chk("t5_lives0", lives_left, 0);
    frames(30);
    chk("t5_over", state, 5);
    chk("t5_high", high_score, 7);
    chk("t5_nrec", new_record, 1);
    flap_press();
    chk("t5_idle", state, 0);
    chk("t5_idle_score", score, 7);
    chk("t5_idle_nrec", new_record, 1);
    flap_press();
    chk("t5_new_game", state, 1);
    chk("t5_new_score", score, 0);
    chk("t5_new_lives", lives_left, 3);
    chk("t5_new_nrec", new_record, 0);
    frames(60);
    incs(4);
    lose_life(); frames(60);
    lose_life(); frames(60);
    lose_life();
    chk("t5_over2", state, 5);
    chk("t5_score2", score, 4);
    chk("t5_high2", high_score, 7);
    chk("t5_nrec2", new_record, 0);

    // 6: saturation on a 3-bit score, then rst mid-PLAY
    b_flap = 1'b1; tick(); b_flap = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin
      b_tick = 1'b1; tick(); b_tick = 1'b0; tick();
    end
    chk("t6_play", b_state, 2);
    for (int i = 0; i < 9; i++) begin
      b_inc = 1'b1; tick(); b_inc = 1'b0; tick();
    end
    chk("t6_saturate", b_score, 7);
    b_flap = 1'b1; tick();
    chk("t6_pulse", b_flap_pulse, 1);
    rst = 1'b1; b_flap = 1'b0; tick();
    chk("t6_rst_state", b_state, 0);
    chk("t6_rst_score", b_score, 0);
    chk("t6_rst_lives", b_lives_left, 3);
    chk("t6_rst_pulse", b_flap_pulse, 0);
    chk("t6_rst_game_rst", b_game_rst, 1);
    chk("t6_rst_freeze", b_freeze, 1);
    chk("t6_rst_high_a", high_score, 0);
    chk("t6_rst_score_a", score, 0);
    rst = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
